wb_branch_resolve_unit: RTL and testbench
=========================================

// Module: wb_branch_resolve_unit
// PURPOSE
//   Registered writeback and branch-resolve stage. Successor to the combinational writeback mux.
//   Accepts one instruction per cycle from MEM under valid/ready. Selects the ALU or MEM result.
//   Holds the architectural NZV flag register and resolves conditional branches against it.
//   On a mispredict it issues a one-cycle redirect to fetch and squashes the wrong-path beats still in flight.
// PARAMETERS
//   DATA_W      16  datapath / PC width
//   REG_ADDR_W  4   register-file address width
//   FLUSH_DEPTH 2   number of accepted beats squashed after a redirect (>=1)
//   STAT_W      16  stats counter width (used only with WB_BRANCH_STATS_EN)
// PORTS
//   clk            in   1           clock
//   rst_n          in   1           async active-low reset
//   in_valid       in   1           MEM beat valid
//   in_ready       out  1           stage can accept
//   in_pc_plus2    in   DATA_W      fall-through PC
//   in_alu         in   DATA_W      ALU result / branch target
//   in_mem         in   DATA_W      load data
//   in_wb_src      in   1           0: ALU, 1: MEM
//   in_reg_we      in   1           instruction writes rd
//   in_rd          in   REG_ADDR_W  destination register
//   in_flag_we     in   3           per-bit flag update enable {N,Z,V}
//   in_flags       in   3           new flag values {N,Z,V}
//   in_branch      in   1           instruction is a branch
//   in_branch_cond in   3           condition code
//   in_pred_taken  in   1           fetch predicted taken
//   out_ready      in   1           register file / downstream can take beat
//   out_valid      out  1           writeback beat valid
//   out_reg_we     out  1           write enable to register file
//   out_rd         out  REG_ADDR_W  write address
//   out_data       out  DATA_W      write data
//   redirect       out  1           one-cycle mispredict pulse
//   redirect_pc    out  DATA_W      corrected PC; valid while redirect=1
//   flags_q        out  3           current committed {N,Z,V}
// BEHAVIOUR
//   - Reset (async, rst_n=0): out_valid=0, out_reg_we=0, out_rd=0, out_data=0, redirect=0, redirect_pc=0.
//     Also flags_q=000, state=IDLE, squash count=0. in_ready=1.
//   - in_ready = !out_valid | out_ready (combinational). accept = in_valid & in_ready.
//   - Output register: latency 1 cycle. Loads on accept of a non-squashed beat.
//     out_data = in_wb_src ? in_mem : in_alu.
//     out_valid clears when out_ready=1 and no new beat loads. Outputs are held stable while out_valid & !out_ready.
//   - Flags: on non-squashed accept, flags_q[i] <= in_flag_we[i] ? in_flags[i] : flags_q[i].
//   - Branch evaluation uses flags_q before this beat's own flag update. Conditions:
//     000 NE Z=0 | 001 EQ Z=1 | 010 GT Z=0&N=0 | 011 LT N=1
//     100 GE Z=1|(Z=0&N=0) | 101 LE N=1|Z=1 | 110 OV V=1 | 111 always.
//   - A branch beat is written back like any other beat, with out_reg_we = in_reg_we.
//   - Mispredict = accept & !squash & in_branch & (taken != in_pred_taken).
//     Next cycle: redirect=1 for exactly 1 cycle; redirect_pc = taken ? in_alu : in_pc_plus2.
//   - FSM IDLE/FLUSH. A mispredict moves the FSM to FLUSH with cnt=FLUSH_DEPTH.
//     In FLUSH each accept drops its beat: no output load, no flag update, no redirect. cnt decrements.
//     FLUSH returns to IDLE when the accept that takes cnt 1->0 completes. Cycles without accept do not decrement.
//   - A branch inside FLUSH is squashed and cannot redirect. There is no simultaneous-redirect case.
//   - Reset mid-FLUSH: returns to IDLE with cnt=0. Any pending redirect is lost.
// CONFIGURATION
//   - WB_BRANCH_STATS_EN defined: adds ports br_count and mispred_count (out, STAT_W each), reset to 0.
//     br_count increments per non-squashed accepted branch. mispred_count increments per mispredict.
//     Both counters saturate at all-ones.
//   - Not defined: ports and counters are absent. All other behaviour is identical.
// TESTING
//   1. Assert rst_n=0 mid-stream during FLUSH -> all outputs 0, flags_q=000, in_ready=1, next beat written normally.
//   2. in_alu=0x1234, wb_src=0, reg_we=1, rd=3 -> next cycle out_valid=1, out_data=0x1234, out_rd=3, out_reg_we=1.
//   3. in_mem=0xBEEF, wb_src=1, out_ready=0 -> in_ready=0; outputs hold 0xBEEF; a 2nd beat loads only after out_ready=1.
//   4. flags_q=101, flag_we=010, flags=010 -> flags_q=111; then flag_we=000 -> flags_q stays 111.
//   5. flags_q Z=1, EQ branch, pred=0, in_alu=0x0040 -> redirect=1 for 1 cycle, redirect_pc=0x0040.
//      Next 2 accepts dropped (out_valid=0, flags unchanged); 3rd accepted beat is written.
//   6. N=1, GT branch, pred=1, pc_plus2=0x0012 -> redirect_pc=0x0012. Cond 111 with pred=1 -> no redirect.
//      With WB_BRANCH_STATS_EN: br_count=2, mispred_count=1.

Source files
------------

// File: rtl/wb_branch_resolve_unit.sv
// Registered writeback + branch resolve: selects ALU/MEM result, commits NZV flags, redirects fetch on mispredict.
// Latency: 1 cycle from accepted MEM beat to writeback beat / redirect pulse.
// Backpressure: in_ready = !out_valid | out_ready; the output beat is held stable while out_valid & !out_ready.
// Optional: define WB_BRANCH_STATS_EN to add saturating branch / mispredict counters (br_count, mispred_count).
module wb_branch_resolve_unit #(
    parameter int DATA_W      = 16,
    parameter int REG_ADDR_W  = 4,
    parameter int FLUSH_DEPTH = 2,
    parameter int STAT_W      = 16
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [DATA_W-1:0]     in_pc_plus2,
    input  logic [DATA_W-1:0]     in_alu,
    input  logic [DATA_W-1:0]     in_mem,
    input  logic                  in_wb_src,
    input  logic                  in_reg_we,
    input  logic [REG_ADDR_W-1:0] in_rd,
    input  logic [2:0]            in_flag_we,
    input  logic [2:0]            in_flags,
    input  logic                  in_branch,
    input  logic [2:0]            in_branch_cond,
    input  logic                  in_pred_taken,
    input  logic                  out_ready,
    output logic                  out_valid,
    output logic                  out_reg_we,
    output logic [REG_ADDR_W-1:0] out_rd,
    output logic [DATA_W-1:0]     out_data,
    output logic                  redirect,
    output logic [DATA_W-1:0]     redirect_pc,
    output logic [2:0]            flags_q
`ifdef WB_BRANCH_STATS_EN
    ,
    output logic [STAT_W-1:0]     br_count,
    output logic [STAT_W-1:0]     mispred_count
`endif
);

    localparam int CNT_W = $clog2(FLUSH_DEPTH + 1);

    typedef enum logic {
        S_IDLE  = 1'b0,
        S_FLUSH = 1'b1
    } state_t;

    state_t                  r_state;
    logic [CNT_W-1:0]        r_cnt;
    logic                    r_redirect;
    logic [DATA_W-1:0]       r_redirect_pc;
    logic                    r_out_valid;
    logic                    r_out_reg_we;
    logic [REG_ADDR_W-1:0]   r_out_rd;
    logic [DATA_W-1:0]       r_out_data;
    logic [2:0]              r_flags;

    logic                    w_in_ready;
    logic                    w_accept;
    logic                    w_squash;
    logic                    w_keep;
    logic                    w_taken;
    logic                    w_mispredict;
    logic [DATA_W-1:0]       w_wb_data;
    logic                    w_n;
    logic                    w_z;
    logic                    w_v;

    assign w_in_ready   = ~r_out_valid | out_ready;
    assign w_accept     = in_valid & w_in_ready;
    assign w_squash     = (r_state == S_FLUSH);
    // A kept beat is one accepted outside the wrong-path window.
    assign w_keep       = w_accept & ~w_squash;
    assign w_wb_data    = in_wb_src ? in_mem : in_alu;
    assign w_n          = r_flags[2];
    assign w_z          = r_flags[1];
    assign w_v          = r_flags[0];
    assign w_mispredict = w_keep & in_branch & (w_taken != in_pred_taken);

    // Branch condition evaluated against committed flags, before this beat's own update.
    always_comb begin
        w_taken = 1'b1;
        case (in_branch_cond)
            3'b000:  w_taken = ~w_z;
            3'b001:  w_taken = w_z;
            3'b010:  w_taken = ~w_z & ~w_n;
            3'b011:  w_taken = w_n;
            3'b100:  w_taken = w_z | (~w_z & ~w_n);
            3'b101:  w_taken = w_n | w_z;
            3'b110:  w_taken = w_v;
            default: w_taken = 1'b1;
        endcase
    end

    // IDLE/FLUSH control with the registered redirect pulse; squash count only moves on accepts.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state       <= S_IDLE;
            r_cnt         <= '0;
            r_redirect    <= 1'b0;
            r_redirect_pc <= '0;
        end else begin
            r_redirect <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (w_mispredict) begin
                        r_state       <= S_FLUSH;
                        r_cnt         <= CNT_W'(FLUSH_DEPTH);
                        r_redirect    <= 1'b1;
                        r_redirect_pc <= w_taken ? in_alu : in_pc_plus2;
                    end
                end
                S_FLUSH: begin
                    if (w_accept) begin
                        r_cnt <= r_cnt - CNT_W'(1);
                        if (r_cnt == CNT_W'(1)) begin
                            r_state <= S_IDLE;
                        end
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                    r_cnt   <= '0;
                end
            endcase
        end
    end

    // Writeback output register: load on kept beat, drain when downstream takes it, else hold.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_out_valid  <= 1'b0;
            r_out_reg_we <= 1'b0;
            r_out_rd     <= '0;
            r_out_data   <= '0;
        end else if (w_keep) begin
            r_out_valid  <= 1'b1;
            r_out_reg_we <= in_reg_we;
            r_out_rd     <= in_rd;
            r_out_data   <= w_wb_data;
        end else if (out_ready) begin
            // Drop the write enable with valid so a consumer ignoring valid never double-writes.
            r_out_valid  <= 1'b0;
            r_out_reg_we <= 1'b0;
        end
    end

    // Architectural NZV register: per-bit update from kept beats only.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_flags <= 3'b000;
        end else if (w_keep) begin
            r_flags <= (in_flag_we & in_flags) | (~in_flag_we & r_flags);
        end
    end

`ifdef WB_BRANCH_STATS_EN
    logic [STAT_W-1:0] r_br_count;
    logic [STAT_W-1:0] r_mispred_count;

    // Saturating counters of resolved branches and mispredicts.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_br_count      <= '0;
            r_mispred_count <= '0;
        end else begin
            if (w_keep && in_branch && (r_br_count != {STAT_W{1'b1}})) begin
                r_br_count <= r_br_count + STAT_W'(1);
            end
            if (w_mispredict && (r_mispred_count != {STAT_W{1'b1}})) begin
                r_mispred_count <= r_mispred_count + STAT_W'(1);
            end
        end
    end

    assign br_count      = r_br_count;
    assign mispred_count = r_mispred_count;
`else
    logic [STAT_W-1:0] w_stats_unused;
    assign w_stats_unused = '0;
`endif

    assign in_ready    = w_in_ready;
    assign out_valid   = r_out_valid;
    assign out_reg_we  = r_out_reg_we;
    assign out_rd      = r_out_rd;
    assign out_data    = r_out_data;
    assign redirect    = r_redirect;
    assign redirect_pc = r_redirect_pc;
    assign flags_q     = r_flags;

endmodule

// File: tb/tb_wb_branch_resolve_unit.sv
// Scoreboard bench for wb_branch_resolve_unit: random + directed MEM beats against a behavioural model.
// Driver pushes expected writebacks/redirects; an independent monitor pops and compares.
// Optional WB_BRANCH_STATS_EN counters are compared against model counts when the macro is defined.
module tb_wb_branch_resolve_unit;

    localparam int DW = 16;
    localparam int AW = 4;
    localparam int FD = 2;
    localparam int SW = 16;

    logic          clk = 1'b0;
    logic          rst_n = 1'b1;
    logic          in_valid = 1'b0;
    logic          in_ready;
    logic [DW-1:0] in_pc_plus2 = '0;
    logic [DW-1:0] in_alu = '0;
    logic [DW-1:0] in_mem = '0;
    logic          in_wb_src = 1'b0;
    logic          in_reg_we = 1'b0;
    logic [AW-1:0] in_rd = '0;
    logic [2:0]    in_flag_we = '0;
    logic [2:0]    in_flags = '0;
    logic          in_branch = 1'b0;
    logic [2:0]    in_branch_cond = '0;
    logic          in_pred_taken = 1'b0;
    logic          out_ready = 1'b1;
    logic          out_valid;
    logic          out_reg_we;
    logic [AW-1:0] out_rd;
    logic [DW-1:0] out_data;
    logic          redirect;
    logic [DW-1:0] redirect_pc;
    logic [2:0]    flags_q;
`ifdef WB_BRANCH_STATS_EN
    logic [SW-1:0] br_count;
    logic [SW-1:0] mispred_count;
`endif

    always #5 clk = ~clk;

    wb_branch_resolve_unit #(
        .DATA_W(DW), .REG_ADDR_W(AW), .FLUSH_DEPTH(FD), .STAT_W(SW)
    ) dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_pc_plus2(in_pc_plus2), .in_alu(in_alu), .in_mem(in_mem),
        .in_wb_src(in_wb_src), .in_reg_we(in_reg_we), .in_rd(in_rd),
        .in_flag_we(in_flag_we), .in_flags(in_flags),
        .in_branch(in_branch), .in_branch_cond(in_branch_cond), .in_pred_taken(in_pred_taken),
        .out_ready(out_ready), .out_valid(out_valid), .out_reg_we(out_reg_we),
        .out_rd(out_rd), .out_data(out_data),
        .redirect(redirect), .redirect_pc(redirect_pc), .flags_q(flags_q)
`ifdef WB_BRANCH_STATS_EN
        , .br_count(br_count), .mispred_count(mispred_count)
`endif
    );

    typedef struct packed {
        logic [DW-1:0] pc2;
        logic [DW-1:0] alu;
        logic [DW-1:0] mem;
        logic          src;
        logic          we;
        logic [AW-1:0] rd;
        logic [2:0]    fwe;
        logic [2:0]    fl;
        logic          br;
        logic [2:0]    cond;
        logic          pred;
    } beat_t;

    typedef struct packed {
        logic [AW-1:0] rd;
        logic [DW-1:0] data;
        logic          we;
    } wb_t;

    typedef struct packed {
        logic [31:0]   cyc;
        logic [DW-1:0] pc;
    } redir_t;

    wb_t         exp_q[$];
    redir_t      red_q[$];
    int          n_chk = 0;
    int          n_fail = 0;
    logic [31:0] cyc = '0;
    logic [2:0]  m_flags = 3'b000;
    logic [2:0]  m_flags_seen = 3'b000;
    int          m_squash = 0;
    int          m_br = 0;
    int          m_mp = 0;
    int          ready_pct = 100;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s @cyc %0d: got 0x%0h expected 0x%0h", name, cyc, act, exp);
        end
    endtask

    // Condition table written straight from the NZV branch rules.
    function automatic logic cond_true(input logic [2:0] c, input logic [2:0] f);
        logic n, z, v;
        n = f[2]; z = f[1]; v = f[0];
        case (c)
            3'd0: return !z;
            3'd1: return z;
            3'd2: return !z && !n;
            3'd3: return n;
            3'd4: return z || (!z && !n);
            3'd5: return n || z;
            3'd6: return v;
            default: return 1'b1;
        endcase
    endfunction

    // Reference model for one accepted beat.
    task automatic model_accept(input beat_t b);
        logic tk;
        if (m_squash > 0) begin
            m_squash--;
        end else begin
            exp_q.push_back('{rd: b.rd, data: (b.src ? b.mem : b.alu), we: b.we});
            if (b.br) begin
                tk = cond_true(b.cond, m_flags);
                m_br++;
                if (tk != b.pred) begin
                    red_q.push_back('{cyc: cyc + 32'd1, pc: (tk ? b.alu : b.pc2)});
                    m_squash = FD;
                    m_mp++;
                end
            end
            for (int i = 0; i < 3; i++) begin
                if (b.fwe[i]) m_flags[i] = b.fl[i];
            end
        end
    endtask

    // One clock of stimulus; reports whether the beat was accepted.
    task automatic do_cycle(input logic rstv, input logic v, input beat_t b, output logic acc);
        @(negedge clk);
        cyc = cyc + 32'd1;
        rst_n = rstv;
        if (!rstv) begin
            exp_q.delete();
            red_q.delete();
            m_flags = 3'b000;
            m_squash = 0;
            m_br = 0;
            m_mp = 0;
        end
        in_valid = v;
        in_pc_plus2 = b.pc2; in_alu = b.alu; in_mem = b.mem;
        in_wb_src = b.src; in_reg_we = b.we; in_rd = b.rd;
        in_flag_we = b.fwe; in_flags = b.fl;
        in_branch = b.br; in_branch_cond = b.cond; in_pred_taken = b.pred;
        out_ready = ($urandom_range(0, 99) < ready_pct);
        #1;
        chk("in_ready", 32'(in_ready), 32'((exp_q.size() == 0) || out_ready));
        m_flags_seen = m_flags;
        acc = v && in_ready && rstv;
        if (acc) model_accept(b);
    endtask

    task automatic send(input beat_t b);
        logic acc;
        int   n;
        acc = 1'b0;
        n = 0;
        while (!acc && n < 64) begin
            do_cycle(1'b1, 1'b1, b, acc);
            n++;
        end
        chk("send_accepted", 32'(acc), 32'd1);
    endtask

    task automatic idle(input int n);
        logic acc;
        for (int i = 0; i < n; i++) do_cycle(1'b1, 1'b0, '0, acc);
    endtask

    function automatic beat_t rand_beat();
        beat_t b;
        b.pc2  = DW'($urandom); b.alu = DW'($urandom); b.mem = DW'($urandom);
        b.src  = 1'($urandom); b.we = 1'($urandom); b.rd = AW'($urandom);
        b.fwe  = 3'($urandom); b.fl = 3'($urandom);
        b.br   = ($urandom_range(0, 2) == 0);
        b.cond = 3'($urandom); b.pred = 1'($urandom);
        return b;
    endfunction

    // Monitor: checks outputs a little after the driver has settled each cycle.
    initial begin
        wb_t e;
        forever begin
            @(negedge clk);
            #2;
            if (!rst_n) begin
                chk("reset_outputs",
                    32'({out_valid, out_reg_we, out_rd, redirect, flags_q}), 32'd0);
                chk("reset_data", {out_data, redirect_pc}, 32'd0);
            end else begin
                chk("flags_q", 32'(flags_q), 32'(m_flags_seen));
                if (red_q.size() > 0 && red_q[0].cyc == cyc) begin
                    chk("redirect_pulse", 32'(redirect), 32'd1);
                    chk("redirect_pc", 32'(redirect_pc), 32'(red_q[0].pc));
                    void'(red_q.pop_front());
                end else begin
                    chk("redirect_idle", 32'(redirect), 32'd0);
                end
                if (out_valid) begin
                    if (exp_q.size() == 0) begin
                        chk("unexpected_beat", 32'(out_valid), 32'd0);
                    end else begin
                        e = exp_q[0];
                        chk("out_data", 32'(out_data), 32'(e.data));
                        chk("out_rd_we", 32'({out_rd, out_reg_we}), 32'({e.rd, e.we}));
                        if (out_ready) void'(exp_q.pop_front());
                    end
                end
            end
        end
    end

    initial begin
        beat_t b;
        logic  acc;
        // Initial reset
        for (int i = 0; i < 3; i++) do_cycle(1'b0, 1'b0, '0, acc);
        idle(2);

        // ALU writeback
        ready_pct = 100;
        b = '0; b.alu = 16'h1234; b.we = 1'b1; b.rd = 4'd3;
        send(b);
        idle(1);

        // MEM writeback under backpressure; second beat must wait
        ready_pct = 0;
        b = '0; b.mem = 16'hBEEF; b.src = 1'b1; b.we = 1'b1; b.rd = 4'd5;
        send(b);
        b.mem = 16'h0001; b.rd = 4'd6;
        for (int i = 0; i < 4; i++) do_cycle(1'b1, 1'b1, b, acc);
        ready_pct = 100;
        send(b);
        idle(2);

        // Per-bit flag update
        b = '0; b.fwe = 3'b111; b.fl = 3'b101; send(b);
        b = '0; b.fwe = 3'b010; b.fl = 3'b010; send(b);
        b = '0; send(b);

        // EQ mispredict with Z=1, then two squashed beats and a written one
        b = '0; b.fwe = 3'b111; b.fl = 3'b010; send(b);
        b = '0; b.br = 1'b1; b.cond = 3'b001; b.pred = 1'b0; b.alu = 16'h0040; send(b);
        for (int i = 0; i < 3; i++) begin
            b = '0; b.alu = DW'(16'h0100 + i); b.we = 1'b1; b.rd = AW'(i);
            b.fwe = 3'b111; b.fl = 3'b111; send(b);
        end
        idle(2);

        // Reset in the middle of a flush window
        b = '0; b.br = 1'b1; b.cond = 3'b111; b.pred = 1'b0; b.alu = 16'h0200; send(b);
        b = '0; b.alu = 16'h0BAD; b.we = 1'b1; send(b);
        do_cycle(1'b0, 1'b0, '0, acc);
        do_cycle(1'b0, 1'b0, '0, acc);

        // GT mispredict with N=1, then always-taken correctly predicted
        b = '0; b.fwe = 3'b111; b.fl = 3'b100; b.alu = 16'h0777; b.we = 1'b1; b.rd = 4'd7; send(b);
        b = '0; b.br = 1'b1; b.cond = 3'b010; b.pred = 1'b1; b.pc2 = 16'h0012; b.alu = 16'h0099; send(b);
        b = '0; send(b);
        b = '0; send(b);
        b = '0; b.br = 1'b1; b.cond = 3'b111; b.pred = 1'b1; b.alu = 16'h0050; send(b);
        idle(2);
`ifdef WB_BRANCH_STATS_EN
        chk("br_count_directed", 32'(br_count), 32'd2);
        chk("mispred_count_directed", 32'(mispred_count), 32'd1);
`endif

        // Randomised traffic with varying backpressure and occasional resets
        for (int i = 0; i < 4000; i++) begin
            if (i % 400 == 0) ready_pct = $urandom_range(20, 100);
            if (i % 1300 == 1299) do_cycle(1'b0, 1'b0, '0, acc);
            else do_cycle(1'b1, ($urandom_range(0, 3) != 0), rand_beat(), acc);
        end

        // Drain
        ready_pct = 100;
        idle(6);
        chk("exp_queue_empty", 32'(exp_q.size()), 32'd0);
        chk("redirect_queue_empty", 32'(red_q.size()), 32'd0);
`ifdef WB_BRANCH_STATS_EN
        chk("br_count_final", 32'(br_count), 32'(m_br));
        chk("mispred_count_final", 32'(mispred_count), 32'(m_mp));
`endif
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
